// File: rtl/prbs9_checker_if.sv
// prbs9_checker_if: serial bit input and lock/BER status bundle for prbs9_checker
interface prbs9_checker_if #(parameter int CNT_W = 32);
   logic i_en, i_valid, i_bit, i_clr_cnt;
   logic o_locked, o_err;
   logic [CNT_W-1:0] o_bit_count, o_err_count;
   modport master(output i_en, i_valid, i_bit, i_clr_cnt, input o_locked, o_err, o_bit_count, o_err_count);
   modport slave(input i_en, i_valid, i_bit, i_clr_cnt, output o_locked, o_err, o_bit_count, o_err_count);
endinterface

// File: rtl/prbs9_checker.sv
// prbs9_checker: self-synchronising PRBS9 (x^9+x^5+1) receiver with lock tracking and BER counters
module prbs9_checker #(
   parameter int LOCK_MATCHES = 16,
   parameter int UNLOCK_ERRS = 8,
   parameter int UNLOCK_WIN = 64,
   parameter int CNT_W = 32
) (
   input logic clk,
   input logic i_reset,
   prbs9_checker_if.slave bus
);
   localparam int WB = $clog2(UNLOCK_WIN);
   localparam int EW = $clog2(UNLOCK_ERRS + 1);
   typedef enum logic {SEARCH, LOCKED} state_t;
   state_t state;
   logic [8:0] hist;
   logic [3:0] fill;
   logic [7:0] match;
   logic [WB-1:0] win_bits;
   logic [EW-1:0] win_errs, errs_next;
   logic [CNT_W-1:0] bit_count, err_count;
   logic err, exp_bit, mis, inc_bit, inc_err;
   always_comb begin
      exp_bit = hist[8] ^ hist[4];
      mis = bus.i_bit ^ exp_bit;
      inc_bit = state == LOCKED && bus.i_en && bus.i_valid;
      inc_err = inc_bit && mis;
      errs_next = win_errs + EW'(mis);
   end
   always_ff @(posedge clk) begin
      if (!i_reset) begin
         state <= SEARCH;
         hist <= '0;
         fill <= '0;
         match <= '0;
         win_bits <= '0;
         win_errs <= '0;
         bit_count <= '0;
         err_count <= '0;
         err <= 1'b0;
      end else begin
         err <= inc_err;
         bit_count <= bus.i_clr_cnt ? '0 : (inc_bit && ~&bit_count) ? bit_count + 1'b1 : bit_count;
         err_count <= bus.i_clr_cnt ? '0 : (inc_err && ~&err_count) ? err_count + 1'b1 : err_count;
         if (!bus.i_en) begin
            state <= SEARCH;
            fill <= '0;
            match <= '0;
            win_bits <= '0;
            win_errs <= '0;
         end else if (bus.i_valid) begin
            // once locked the replica free-runs so line errors never corrupt it
            hist <= {hist[7:0], state == LOCKED ? exp_bit : bus.i_bit};
            if (state == SEARCH) begin
               if (fill != 4'd9) fill <= fill + 4'd1;
               else if (mis || hist == '0) match <= '0;
               else if (match == 8'(LOCK_MATCHES - 1)) begin
                  state <= LOCKED;
                  match <= '0;
                  win_bits <= '0;
                  win_errs <= '0;
               end else match <= match + 8'd1;
            end else begin
               win_bits <= win_bits + 1'b1;
               if (errs_next == EW'(UNLOCK_ERRS)) begin
                  state <= SEARCH;
                  fill <= '0;
                  match <= '0;
                  win_bits <= '0;
                  win_errs <= '0;
               end else win_errs <= win_bits == WB'(UNLOCK_WIN - 1) ? '0 : errs_next;
            end
         end
      end
   end
   assign bus.o_locked = state == LOCKED;
   assign bus.o_err = err;
   assign bus.o_bit_count = bit_count;
   assign bus.o_err_count = err_count;
endmodule

// File: tb/tb_prbs9_checker.sv
// tb_prbs9_checker: randomized and directed checks of prbs9_checker against a recurrence-based model
module tb_prbs9_checker;
   localparam int CW = 10;
   localparam longint CMAX = (64'd1 << CW) - 1;
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;
   prbs9_checker_if #(.CNT_W(CW)) bus();
   prbs9_checker #(.CNT_W(CW)) dut(.clk(clk), .i_reset(rst), .bus(bus));
   int n_tests = 0, n_fail = 0;
   bit pat[511];
   int gi = 0;
   bit q[$];
   bit m_locked, m_err;
   int m_fill, m_match, m_wpos, m_werr;
   longint m_bits, m_errs;

   function automatic bit nb();
      nb = pat[gi % 511];
      gi++;
   endfunction

   // b[n] = b[n-9] ^ b[n-5] with q[0] = b[n-9], q[4] = b[n-5]
   function automatic void model(bit r, bit en, bit v, bit b, bit clr);
      bit e, nz, mis;
      m_err = 0;
      if (!r) begin
         q.delete();
         repeat (9) q.push_back(1'b0);
         m_locked = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_bits = 0; m_errs = 0;
         return;
      end
      if (clr) begin m_bits = 0; m_errs = 0; end
      if (!en) begin
         m_locked = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
         return;
      end
      if (!v) return;
      e = q[0] ^ q[4];
      nz = 0;
      foreach (q[i]) nz |= q[i];
      mis = b != e;
      void'(q.pop_front());
      q.push_back(m_locked ? e : b);
      if (!m_locked) begin
         if (m_fill < 9) m_fill++;
         else if (mis || !nz) m_match = 0;
         else begin
            m_match++;
            if (m_match == 16) begin m_locked = 1; m_match = 0; m_wpos = 0; m_werr = 0; end
         end
      end else begin
         if (!clr && m_bits < CMAX) m_bits++;
         if (mis) begin
            m_err = 1;
            if (!clr && m_errs < CMAX) m_errs++;
            m_werr++;
         end
         m_wpos++;
         if (m_werr == 8) begin m_locked = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; end
         else if (m_wpos == 64) begin m_wpos = 0; m_werr = 0; end
      end
   endfunction

   task automatic drive(input bit en, input bit v, input bit b, input bit clr);
      bus.i_en = en; bus.i_valid = v; bus.i_bit = b; bus.i_clr_cnt = clr;
      @(posedge clk);
      model(rst, en, v, b, clr);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (5) drive(1, 1, 1'($urandom), 0);
      n_tests += 4;
      if (bus.o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", bus.o_locked); end
      if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.o_err); end
      if (bus.o_bit_count !== '0) begin n_fail++; $display("FAIL reset_bits: got %0d want 0", bus.o_bit_count); end
      if (bus.o_err_count !== '0) begin n_fail++; $display("FAIL reset_errs: got %0d want 0", bus.o_err_count); end
      rst = 1'b1;
      repeat (5) drive(1, 0, 1'($urandom), 0);
      n_tests += 2;
      if (bus.o_locked !== 1'b0 || bus.o_err !== 1'b0) begin n_fail++; $display("FAIL idle_flags: locked=%b err=%b want 0 0", bus.o_locked, bus.o_err); end
      if (bus.o_bit_count !== '0 || bus.o_err_count !== '0) begin n_fail++; $display("FAIL idle_counts: got %0d/%0d want 0/0", bus.o_bit_count, bus.o_err_count); end
   endtask

   task automatic test_lock();
      int rise = -1;
      for (int k = 0; k < 536; k++) begin
         drive(1, 1, nb(), 0);
         n_tests++;
         if (bus.o_locked !== m_locked || bus.o_err !== 1'b0) begin
            n_fail++; $display("FAIL lock_cycle %0d: locked=%b err=%b want %b 0", k, bus.o_locked, bus.o_err, m_locked);
         end
         if (rise < 0 && bus.o_locked === 1'b1) rise = k + 1;
      end
      n_tests += 3;
      if (rise !== 25) begin n_fail++; $display("FAIL lock_time: got %0d want 25", rise); end
      if (bus.o_bit_count !== CW'(511)) begin n_fail++; $display("FAIL lock_bits: got %0d want 511", bus.o_bit_count); end
      if (bus.o_err_count !== '0) begin n_fail++; $display("FAIL lock_errs: got %0d want 0", bus.o_err_count); end
   endtask

   task automatic test_single_err();
      int pulses = 0;
      bit b;
      for (int k = 0; k < 100; k++) begin
         b = nb();
         drive(1, 1, k == 30 ? ~b : b, 0);
         pulses += int'(bus.o_err);
         n_tests++;
         if (bus.o_locked !== 1'b1 || bus.o_err !== m_err) begin
            n_fail++; $display("FAIL single_cycle %0d: locked=%b err=%b want 1 %b", k, bus.o_locked, bus.o_err, m_err);
         end
      end
      n_tests += 2;
      if (pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulses); end
      if (bus.o_err_count !== CW'(1)) begin n_fail++; $display("FAIL single_errs: got %0d want 1", bus.o_err_count); end
   endtask

   task automatic test_burst();
      int n = 0;
      repeat (10) drive(1, 1, nb(), 0);
      for (int j = 0; j < 8; j++) begin
         drive(1, 1, ~nb(), 0);
         n_tests++;
         if (bus.o_locked !== (j < 7) || bus.o_err !== 1'b1) begin
            n_fail++; $display("FAIL burst_bit %0d: locked=%b err=%b want %b 1", j, bus.o_locked, bus.o_err, j < 7);
         end
      end
      n_tests++;
      if (bus.o_err_count !== CW'(9)) begin n_fail++; $display("FAIL burst_errs: got %0d want 9", bus.o_err_count); end
      do begin drive(1, 1, nb(), 0); n++; end while (bus.o_locked !== 1'b1 && n < 100);
      n_tests++;
      if (n !== 25) begin n_fail++; $display("FAIL relock_time: got %0d want 25", n); end
      repeat (50) drive(1, 1, nb(), 0);
      n_tests += 2;
      if (bus.o_err_count !== CW'(9)) begin n_fail++; $display("FAIL relock_errs: got %0d want 9", bus.o_err_count); end
      if (bus.o_bit_count !== CW'(m_bits)) begin n_fail++; $display("FAIL relock_bits: got %0d want %0d", bus.o_bit_count, m_bits); end
   endtask

   task automatic test_zero_and_gapped();
      int seen = 0, cnt = 0, rise = -1, guard = 0;
      bit v;
      rst = 1'b0; repeat (2) drive(1, 0, 0, 0); rst = 1'b1;
      repeat (1000) begin drive(1, 1, 0, 0); seen += int'(bus.o_locked); end
      n_tests += 2;
      if (seen !== 0) begin n_fail++; $display("FAIL zero_lock: locked for %0d cycles want 0", seen); end
      if (bus.o_bit_count !== '0 || bus.o_err_count !== '0) begin n_fail++; $display("FAIL zero_counts: got %0d/%0d want 0/0", bus.o_bit_count, bus.o_err_count); end
      rst = 1'b0; repeat (2) drive(1, 0, 0, 0); rst = 1'b1;
      gi = 0;
      while (cnt < 536 && guard < 5000) begin
         v = 1'($urandom);
         drive(1, v, v ? nb() : 1'($urandom), 0);
         cnt += int'(v);
         guard++;
         if (rise < 0 && bus.o_locked === 1'b1) rise = cnt;
      end
      n_tests += 4;
      if (cnt !== 536) begin n_fail++; $display("FAIL gap_budget: got %0d valid bits want 536", cnt); end
      if (rise !== 25) begin n_fail++; $display("FAIL gap_lock_time: got %0d want 25", rise); end
      if (bus.o_bit_count !== CW'(511)) begin n_fail++; $display("FAIL gap_bits: got %0d want 511", bus.o_bit_count); end
      if (bus.o_err_count !== '0) begin n_fail++; $display("FAIL gap_errs: got %0d want 0", bus.o_err_count); end
   endtask

   task automatic test_clr_en();
      int n = 0;
      repeat (5) drive(1, 1, nb(), 0);
      drive(1, 1, ~nb(), 1);
      n_tests++;
      if (bus.o_err !== 1'b1 || bus.o_bit_count !== '0 || bus.o_err_count !== '0) begin
         n_fail++; $display("FAIL clr_cnt: err=%b counts=%0d/%0d want 1 0/0", bus.o_err, bus.o_bit_count, bus.o_err_count);
      end
      repeat (10) drive(1, 1, nb(), 0);
      repeat (3) drive(0, 1, 1'($urandom), 0);
      n_tests++;
      if (bus.o_locked !== 1'b0 || bus.o_bit_count !== CW'(10) || bus.o_err_count !== '0) begin
         n_fail++; $display("FAIL en_low: locked=%b counts=%0d/%0d want 0 10/0", bus.o_locked, bus.o_bit_count, bus.o_err_count);
      end
      do begin drive(1, 1, nb(), 0); n++; end while (bus.o_locked !== 1'b1 && n < 100);
      n_tests += 2;
      if (n !== 25) begin n_fail++; $display("FAIL en_relock: got %0d want 25", n); end
      if (bus.o_bit_count !== CW'(10)) begin n_fail++; $display("FAIL en_hold_bits: got %0d want 10", bus.o_bit_count); end
   endtask

   task automatic test_window();
      bit b;
      longint e0 = m_errs;
      for (int k = 0; k < 200; k++) begin
         b = nb();
         drive(1, 1, k % 10 == 9 ? ~b : b, 0);
         n_tests++;
         if (bus.o_locked !== 1'b1 || bus.o_err !== m_err) begin
            n_fail++; $display("FAIL window_cycle %0d: locked=%b err=%b want 1 %b", k, bus.o_locked, bus.o_err, m_err);
         end
      end
      n_tests++;
      if (bus.o_err_count !== CW'(e0 + 20)) begin n_fail++; $display("FAIL window_errs: got %0d want %0d", bus.o_err_count, e0 + 20); end
   endtask

   task automatic test_saturate();
      repeat (1100) drive(1, 1, nb(), 0);
      n_tests++;
      if (bus.o_bit_count !== CW'(CMAX)) begin n_fail++; $display("FAIL sat_bits: got %0d want %0d", bus.o_bit_count, CMAX); end
   endtask

   task automatic test_random();
      bit en, v, clr;
      for (int k = 0; k < 3000; k++) begin
         rst = $urandom_range(199) != 0;
         en = $urandom_range(49) != 0;
         v = $urandom_range(3) != 0;
         clr = $urandom_range(99) == 0;
         drive(en, v, (en && v) ? nb() ^ ($urandom_range(11) == 0) : 1'($urandom), clr);
         n_tests++;
         if (bus.o_locked !== m_locked || bus.o_err !== m_err || bus.o_bit_count !== CW'(m_bits) || bus.o_err_count !== CW'(m_errs)) begin
            n_fail++;
            $display("FAIL random_cycle %0d: got %b %b %0d %0d want %b %b %0d %0d", k, bus.o_locked, bus.o_err,
                     bus.o_bit_count, bus.o_err_count, m_locked, m_err, m_bits, m_errs);
         end
      end
      rst = 1'b1;
   endtask

   initial begin
      logic [8:0] s = 9'h1FF;
      for (int k = 0; k < 511; k++) begin
         pat[k] = s[8];
         s = {s[7:0], s[8] ^ s[4]};
      end
      test_reset();
      test_lock();
      test_single_err();
      test_burst();
      test_zero_and_gapped();
      test_clr_en();
      test_window();
      test_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
